// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encoding and default width for the countdown timer
package countdown_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/down_count_core.sv
// down_count_core: count register, reload register, decrement and terminal detect
module down_count_core import countdown_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  input  logic             reload,
  output logic [WIDTH-1:0] q,
  output logic             q_is_one
);
  logic [WIDTH-1:0] reload_reg;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      q <= '0;
      reload_reg <= '0;
    end else if (clear) q <= '0;
    else if (load) begin
      q <= load_val;
      reload_reg <= load_val;
    end else if (reload) q <= reload_reg;
    else if (dec && q != '0) q <= q - 1'b1;
  assign q_is_one = q == WIDTH'(1);
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-shot and auto-reload terminal count
module countdown_timer import countdown_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);
  state_t state, state_d;
  logic tc_d, dec, reload, q_is_one, expire;
  down_count_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .dec(dec), .reload(reload), .q(q), .q_is_one(q_is_one)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      tc <= 1'b0;
    end else begin
      state <= state_d;
      tc <= tc_d;
    end
  always_comb begin
    expire = !clear && !load && state == RUN && en && q_is_one;
    tc_d = expire;
    reload = expire && auto_reload;
    dec = !clear && !load && state == RUN && en && !reload;
    state_d = clear ? IDLE :
              load ? (load_val != '0 ? RUN : IDLE) :
              (expire && !auto_reload) ? DONE : state;
  end
  assign busy = state == RUN;
  assign done = state == DONE;
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable synchronous down-counter with terminal-count detection, one-shot and auto-reload modes. It is the counting-down companion to the team's 4-bit ripple up-counter. It provides programmable delays and periodic ticks to neighbouring control logic. All state is on one clock with a single asynchronous active-low reset.

## Interface
- WIDTH, default 4: counter and load-value width in bits.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low. rst=0 forces reset state immediately, independent of clk.
- clear  input  1  synchronous clear; returns block to IDLE.
- load  input  1  synchronous load strobe; samples load_val.
- load_val  input  WIDTH  start/reload value.
- en  input  1  count enable; one decrement per enabled cycle in RUN.
- auto_reload  input  1  0 = one-shot, 1 = periodic; sampled every cycle.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, high exactly one cycle per expiry.
- busy  output  1  high while state is RUN.
- done  output  1  sticky one-shot completion flag.

## Operation
- State machine states:
  - IDLE: reset state. q=0, busy=0, done=0.
  - RUN: counting. busy=1.
  - DONE: one-shot expired. q=0, busy=0, done=1.
- Priority at each edge, highest first:
  - clear: go to IDLE; q=0, tc=0, done=0; reload register unchanged.
  - load:
    - reload_reg <= load_val; q <= load_val; tc=0; done=0.
    - If load_val != 0, go to RUN; otherwise go to IDLE.
    - load is legal in any state and restarts the count.
  - RUN with en=1 and q > 1: q <= q-1.
  - RUN with en=1 and q == 1:
    - tc <= 1.
    - If auto_reload=1: q <= reload_reg, stay in RUN. The count never shows 0; period = reload_reg enabled cycles.
    - Else: q <= 0, go to DONE, done <= 1.
  - RUN with en=0: hold q. tc <= 0.
  - IDLE or DONE without clear or load: hold. en is ignored. q never underflows below 0.
- tc defaults to 0 on every edge where the terminal condition is not met.
- Arithmetic is unsigned WIDTH bits. No wrap from 0 to 2^WIDTH-1 is ever possible.

## Timing
- Reset values, asserted asynchronously while rst=0: q=0, tc=0, busy=0, done=0, reload_reg=0, state=IDLE.
- Reset deassertion: first active edge is the first clk rising edge with rst=1.
- Load latency: load sampled at edge k gives q=load_val and busy=1 after edge k.
- One-shot, load value N at edge k with en held high: q reaches 0 and tc=1 after edge k+N; done=1 from the same edge.
- tc is high for exactly one cycle. It coincides with q=0 (one-shot) or q=reload_reg (auto-reload).
- Reset mid-count drops all outputs in the same cycle. No tc is generated.
- Changing auto_reload mid-count takes effect at the next terminal edge.

## Structure
- Shared package `countdown_pkg` holds:
  - state enum: IDLE, RUN, DONE;
  - default WIDTH constant.
- One sub-module, `down_count_core`:
  - holds the q register, reload_reg, the decrement and the q==1 detect;
  - control inputs: clear, load, dec, reload.
- The top module holds the FSM, tc, done and busy.

## Test plan
- Reset: load 9, run 3 cycles, pull rst=0 between edges -> q=0, tc=0, busy=0, done=0 immediately; first edge after rst=1 with no load keeps IDLE.
- One-shot: WIDTH=4, load 5, auto_reload=0, en=1 -> q sequence 5,4,3,2,1,0; tc=1 only in the q=0 cycle; done=1 and busy=0 afterwards; 10 further en cycles keep q=0, tc=0.
- Auto-reload: load 3, auto_reload=1, en=1 -> q sequence 3,2,1,3,2,1,3; tc high in each cycle q returns to 3, i.e. every 3rd cycle; load 1 -> tc high every cycle with q=1.
- Enable and restart: load 8, en toggling 1,0,0,1 -> q 8,7,7,7,6; load 12 while q=6 -> q=12 next cycle, done stays 0.
- Priority: clear=1 and load=1 in the same cycle -> IDLE, q=0; load 0 -> IDLE, busy=0, no tc.
- Maximum value: load 15 -> tc after exactly 15 enabled cycles.
